// File: rtl/led_share_arbiter.sv
// Round-robin owner selection for the shared board LED, with time-slice
// preemption, an enforced off-gap between owners and a PWM dimmer for the owner.
module led_share_arbiter #(
  parameter int N_REQ        = 4,
  parameter int PWM_BITS     = 8,
  parameter int SLICE_CYCLES = 50_000_000,
  parameter int GAP_CYCLES   = 1_000_000
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ*PWM_BITS-1:0] LEVEL,
  output logic [N_REQ-1:0]          GNT,
  output logic                      LED,
  output logic                      BUSY
);

  localparam int OW = $clog2(N_REQ);
  localparam int SW = $clog2(SLICE_CYCLES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PWM_BITS-1:0] PWM_LAST   = ~PWM_BITS'(1);
  localparam logic [SW-1:0]       SLICE_LAST = SW'(SLICE_CYCLES - 1);
  localparam logic [GW-1:0]       GAP_LAST   = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t              state;
  logic [OW-1:0]       last_owner;
  logic [SW-1:0]       slice_cnt;
  logic [GW-1:0]       gap_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level_q;

  logic                pick_valid;
  logic [OW-1:0]       pick_idx;
  logic [OW:0]         cand;
  logic [PWM_BITS-1:0] pick_level;
  logic [PWM_BITS-1:0] own_level;
  logic [PWM_BITS-1:0] pwm_next;
  logic [PWM_BITS-1:0] level_next;
  logic                others_req;

  // Search upward from the previous owner so it ends up with lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_owner} + (OW+1)'(k);
      if (cand >= (OW+1)'(N_REQ)) cand = cand - (OW+1)'(N_REQ);
      if (!pick_valid && REQ[cand[OW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[OW-1:0];
      end
    end
  end

  always_comb begin
    pick_level = LEVEL[pick_idx*PWM_BITS +: PWM_BITS];
    own_level  = LEVEL[last_owner*PWM_BITS +: PWM_BITS];
    pwm_next   = (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
    level_next = (pwm_next == '0) ? own_level : level_q;
    others_req = |(REQ & ~(N_REQ'(1) << last_owner));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      last_owner <= OW'(N_REQ - 1);
      slice_cnt  <= '0;
      gap_cnt    <= '0;
      pwm_cnt    <= '0;
      level_q    <= '0;
      GNT        <= '0;
      LED        <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state      <= OWN;
            BUSY       <= 1'b1;
            GNT        <= N_REQ'(1) << pick_idx;
            last_owner <= pick_idx;
            slice_cnt  <= '0;
            pwm_cnt    <= '0;
            level_q    <= pick_level;
            LED        <= (pick_level != '0);
          end
        end
        OWN: begin
          // Release and preemption both land in GAP, so one branch covers both.
          if (!REQ[last_owner] || (slice_cnt == SLICE_LAST && others_req)) begin
            state   <= GAP;
            gap_cnt <= '0;
            GNT     <= '0;
            LED     <= 1'b0;
          end else begin
            slice_cnt <= (slice_cnt == SLICE_LAST) ? '0 : slice_cnt + 1'b1;
            pwm_cnt   <= pwm_next;
            level_q   <= level_next;
            LED       <= (pwm_next < level_next);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (pick_valid) begin
              state      <= OWN;
              GNT        <= N_REQ'(1) << pick_idx;
              last_owner <= pick_idx;
              slice_cnt  <= '0;
              pwm_cnt    <= '0;
              level_q    <= pick_level;
              LED        <= (pick_level != '0);
            end else begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          GNT   <= '0;
          LED   <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
